// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, FSM state encoding and accumulator sizing for the serial FIR stage.
package fir_pkg;
  localparam int DW = 4;
  localparam int PW = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;
  function automatic int acc_w(input int ntaps);
    return 2 * DW + $clog2(ntaps);
  endfunction
endpackage

// File: rtl/fir_serial_mac_if.sv
// fir_serial_mac_if: sample input, coefficient write and result output handshakes.
interface fir_serial_mac_if
  import fir_pkg::*;
#(parameter int NTAPS = 4);
  localparam int AW = $clog2(NTAPS);
  localparam int ACCW = acc_w(NTAPS);
  logic in_valid, in_ready;
  logic signed [DW-1:0] in_data;
  logic coef_we;
  logic [AW-1:0] coef_addr;
  logic signed [DW-1:0] coef_data;
  logic out_valid, out_ready;
  logic signed [ACCW-1:0] out_data;
  modport master (output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
                  input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
                 output in_ready, out_valid, out_data);
endinterface

// File: rtl/baugh_wooley_multiplier.sv
// baugh_wooley_multiplier: combinational 4x4 signed multiplier with an 8-bit two's-complement product.
module baugh_wooley_multiplier (
  input  logic signed [3:0] a,
  input  logic signed [3:0] b,
  output logic signed [7:0] p
);
  // Partial products touching exactly one sign bit are inverted; 0x90 restores the bias.
  always_comb begin
    p = 8'h90;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        p = p + (8'(((i == 3) != (j == 3)) ^ (a[i] & b[j])) << (i + j));
  end
endmodule

// File: rtl/fir_serial_mac.sv
// fir_serial_mac: time-multiplexed FIR stage, one tap product per cycle through a shared multiplier.
module fir_serial_mac
  import fir_pkg::*;
#(parameter int NTAPS = 4) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic busy,
  fir_serial_mac_if.slave bus
);
  localparam int AW = $clog2(NTAPS);
  localparam int ACCW = acc_w(NTAPS);
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);
  state_t state;
  logic signed [DW-1:0] x [NTAPS];
  logic signed [DW-1:0] h [NTAPS];
  logic signed [ACCW-1:0] acc, sum;
  logic signed [PW-1:0] prod;
  logic [AW-1:0] idx;
  assign bus.in_ready = state == IDLE;
  assign busy = state != IDLE;
  baugh_wooley_multiplier mul (.a(x[idx]), .b(h[idx]), .p(prod));
  assign sum = acc + {{(ACCW-PW){prod[PW-1]}}, prod};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      for (int k = 0; k < NTAPS; k++) begin
        x[k] <= '0;
        h[k] <= '0;
      end
      acc <= '0;
      idx <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
    end else if (clr) begin
      state <= IDLE;
      for (int k = 0; k < NTAPS; k++) x[k] <= '0;
      acc <= '0;
      idx <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.coef_we && int'(bus.coef_addr) < NTAPS) h[bus.coef_addr] <= bus.coef_data;
          if (bus.in_valid) begin
            x[0] <= bus.in_data;
            for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
            acc <= '0;
            idx <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= sum;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            bus.out_data <= sum;
            bus.out_valid <= 1'b1;
            state <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_serial_mac.sv
// tb_fir_serial_mac: directed and randomized checks of the serial FIR against a convolution model.
module tb_fir_serial_mac;
  localparam int NT = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic busy;
  int passed = 0, failed = 0, total = 0;
  int hm [NT];
  int xm [NT];
  fir_serial_mac_if #(.NTAPS(NT)) bus ();
  fir_serial_mac #(.NTAPS(NT)) dut (.clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy), .bus(bus));
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_y();
    int s = 0;
    for (int k = 0; k < NT; k++) s += hm[k] * xm[k];
    return s;
  endfunction

  function automatic int rnd4();
    return int'($urandom_range(0, 15)) - 8;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_coef(input int a, input int d);
    bus.coef_we = 1'b1;
    bus.coef_addr = 2'(a);
    bus.coef_data = 4'(d);
    tick();
    bus.coef_we = 1'b0;
    hm[a] = d;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < NT; k++) xm[k] = 0;
  endtask

  task automatic send(input int s);
    bus.in_valid = 1'b1;
    bus.in_data = 4'(s);
    tick();
    bus.in_valid = 1'b0;
    for (int k = NT - 1; k > 0; k--) xm[k] = xm[k-1];
    xm[0] = s;
  endtask

  task automatic wait_out(input bit wr_busy);
    int n = 0;
    if (wr_busy) begin
      bus.coef_we = 1'b1;
      bus.coef_addr = 2'd0;
      bus.coef_data = 4'sd5;
    end
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
      bus.coef_we = 1'b0;
    end
    check("latency", n, NT);
  endtask

  // One full transaction; hold > 0 keeps out_ready low while offering ignored samples.
  task automatic run_sample(input int s, input int hold, input bit wr_busy);
    int e;
    check("in_ready_idle", bus.in_ready, 1);
    send(s);
    wait_out(wr_busy);
    e = exp_y();
    check("out_data", bus.out_data, e);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 4'(rnd4());
      tick();
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    if (hold > 0) begin
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_stable", bus.out_data, e);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("out_valid_drop", bus.out_valid, 0);
    check("in_ready_after", bus.in_ready, 1);
  endtask

  initial begin
    int cnt;
    int e;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.coef_we = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < NT; k++) begin
      hm[k] = 0;
      xm[k] = 0;
    end
    repeat (3) tick();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    rst_n = 1'b1;
    tick();

    set_coef(0, 1); set_coef(1, 2); set_coef(2, -3); set_coef(3, 7);
    run_sample(1, 0, 0);
    run_sample(0, 0, 0);
    run_sample(0, 0, 0);
    run_sample(0, 0, 0);
    check("impulse_last", exp_y(), 7);

    for (int k = 0; k < NT; k++) set_coef(k, -8);
    for (int i = 0; i < NT; i++) run_sample(-8, 0, 0);
    check("extreme_pos", bus.out_data, 256);
    for (int k = 0; k < NT; k++) set_coef(k, 7);
    do_clr();
    for (int i = 0; i < NT; i++) run_sample(-8, 0, 0);
    check("extreme_neg", bus.out_data, -224);

    run_sample(rnd4(), 10, 0);

    set_coef(0, 1); set_coef(1, 2); set_coef(2, -3); set_coef(3, 7);
    run_sample(3, 0, 1);
    set_coef(0, 5);
    run_sample(2, 0, 0);

    set_coef(0, 1); set_coef(1, 0); set_coef(2, 0); set_coef(3, 0);
    send(6);
    tick();
    do_clr();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) cnt++;
      tick();
    end
    check("clr_no_out", cnt, 0);
    check("clr_busy", busy, 0);
    run_sample(3, 0, 0);
    check("clr_history", bus.out_data, 3);

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) set_coef(int'($urandom_range(0, NT - 1)), rnd4());
      run_sample(rnd4(), int'($urandom_range(0, 2)), 0);
    end

    send(rnd4());
    wait_out(0);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", bus.out_valid, 0);
    check("async_busy", busy, 0);
    check("async_out_data", bus.out_data, 0);
    #3 rst_n = 1'b1;
    for (int k = 0; k < NT; k++) begin
      hm[k] = 0;
      xm[k] = 0;
    end
    tick();
    run_sample(rnd4(), 0, 0);
    e = exp_y();
    check("post_rst_zero", bus.out_data, e);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fir_serial_mac.md
Name: fir_serial_mac

Overview:
- Time-multiplexed FIR filter stage that consumes the 8-bit signed products of the team's 4x4 Baugh-Wooley multiplier.
- Holds an NTAPS-deep delay line of 4-bit signed samples and NTAPS programmable 4-bit signed coefficients.
- For each accepted sample, sequences one multiply per cycle through a single multiplier instance and accumulates the products.
- Presents the filtered result on a valid/ready output; sits between the sample source and the IIR/output stage of the filter chain.

Parameters:
- NTAPS, 4, number of taps (delay-line depth and coefficient count); legal range 2..16.
- DW, 4, sample and coefficient width; fixed at 4 by the multiplier, not to be overridden.
- ACCW, 2*DW+$clog2(NTAPS) (=10), accumulator and output width; guarantees no overflow.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush of delay line and accumulator
- in_valid  in  1  sample available
- in_ready  out  1  block can accept a sample
- in_data  in  DW  signed two's-complement sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(NTAPS)  coefficient index
- coef_data  in  DW  signed coefficient
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  ACCW  signed filter output y[n] = sum h[k]*x[n-k]
- busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; delay line, coefficients, accumulator, tap index and out_data = 0; out_valid = 0.
  - in_ready = 1 and busy = 0 immediately after reset, since both are decoded from state.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: x[0] <= in_data, x[k] <= x[k-1] for k = 1..NTAPS-1; acc <= 0; idx <= 0; go to MAC.
- MAC:
  - in_ready = 0.
  - Each cycle: acc <= acc + sext(x[idx]*h[idx]); the product is sign-extended from 8 bits to ACCW bits.
  - idx increments each cycle. When idx == NTAPS-1: out_data <= final sum; out_valid <= 1; go to OUT.
  - Exactly NTAPS MAC cycles per sample.
- OUT:
  - out_valid and out_data are held stable until out_ready.
  - On out_valid && out_ready: out_valid <= 0; go to IDLE.
- Latency and throughput:
  - out_valid rises NTAPS clock edges after the accepting edge.
  - With out_ready held high, throughput is one sample per NTAPS+2 cycles.
- Multiplier: combinational, 4x4 signed to 8-bit two's complement. The operand pair (x[idx], h[idx]) is muxed from the registers. Product range is -56..64.
- Coefficient writes:
  - Honoured only in IDLE; h[coef_addr] <= coef_data at the clock edge.
  - Ignored silently in MAC/OUT.
  - A write and a sample accept in the same IDLE cycle both take effect; the MAC uses the new coefficient.
- clr:
  - Takes priority over all other actions. Zeroes the delay line and accumulator, sets out_valid = 0, state = IDLE.
  - Coefficients are retained.
  - If clr arrives in MAC or OUT, the in-flight result is discarded.
- Reset mid-operation: asynchronous return to the reset values above; no partial output.
- Handshake rules: in_data is sampled only on a handshake. out_data changes only when entering OUT. out_valid never drops without out_ready, except on clr or reset.

Decomposition:
- Shared package fir_pkg holds:
  - DW = 4 and PW = 8 (product width).
  - FSM state encodings IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2.
  - ACCW computation helper.
- One sub-module: the existing baugh_wooley_multiplier, instantiated exactly once for the product path.
- Delay line, coefficient bank, accumulator and FSM stay in fir_serial_mac.

Test Plan:
- Impulse: h = {1,2,-3,7}; samples 1,0,0,0 -> out_data 1, 2, -3, 7; each out_valid arrives 4 cycles after its accept.
- Extremes: all h = -8; samples -8 x4 -> 4th output = 256. Then all h = 7; after clr, samples -8 x4 -> 4th output = -224, with no wrap.
- Backpressure: hold out_ready = 0 for 10 cycles in OUT -> out_data stable, in_ready = 0, in_valid ignored. Release -> one handshake, then in_ready = 1 the next cycle.
- Coefficient write while busy: write h[0] = 5 during MAC -> ignored; output uses the old h[0]. The same write in IDLE takes effect on the next sample.
- clr during MAC (2nd MAC cycle) -> no out_valid; next sample 3 with h = {1,0,0,0} gives out_data = 3 (prior history gone).
- Async reset asserted mid-OUT -> out_valid = 0 within the same cycle (no clock edge); after release, coefficients read back as 0 and the next output is 0.
